// File: rtl/fetch_stage_pkg.sv
// Shared core definitions for instruction fetch: bubble encoding, reset PC and
// the memory-map region codes reused by the execute-stage memory decoder.
package fetch_stage_pkg;

  localparam int          W_SIZE_DEFAULT   = 32;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0000;

  localparam logic [3:0] REGION_BIOS = 4'b0100;
  localparam logic [3:0] REGION_IMEM = 4'b0001;

  typedef enum logic [1:0] {
    REGION_SEL_BIOS = 2'd0,
    REGION_SEL_IMEM = 2'd1,
    REGION_SEL_NONE = 2'd2
  } region_sel_e;

  // Decodes the top address nibble into the instruction source it maps to.
  function automatic region_sel_e region_decode(input logic [3:0] addr_hi);
    region_sel_e sel;
    case (addr_hi)
      REGION_BIOS: sel = REGION_SEL_BIOS;
      REGION_IMEM: sel = REGION_SEL_IMEM;
      default:     sel = REGION_SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read port shared by BIOS and IMEM: one address out,
// two synchronous-read data buses back with 1-cycle latency.
interface fetch_stage_if #(
  parameter int W_SIZE = 32
);
  logic [W_SIZE-1:0] fetch_addr;
  logic [W_SIZE-1:0] bios_dout;
  logic [W_SIZE-1:0] imem_dout;

  modport master (
    output fetch_addr,
    input  bios_dout,
    input  imem_dout
  );

  modport slave (
    input  fetch_addr,
    output bios_dout,
    output imem_dout
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues the shared BIOS/IMEM read
// address and presents the returned word with its PC to decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                W_SIZE   = W_SIZE_DEFAULT,
  parameter logic [W_SIZE-1:0] RESET_PC = W_SIZE'(RESET_PC_DEFAULT),
  parameter logic [W_SIZE-1:0] NOP      = W_SIZE'(NOP_INST)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [W_SIZE-1:0] redirect_pc,
  fetch_stage_if.master     mem,
  output logic [W_SIZE-1:0] pc_fd,
  output logic [W_SIZE-1:0] inst_fd,
  output logic              valid_fd,
  output logic              fetch_fault,
  output logic [31:0]       fetch_count
);

  // Decode handshake: valid_fd=1 means inst_fd/pc_fd hold a real correct-path
  // instruction; decode accepts it on any edge where stall=0, otherwise the
  // same pair is re-presented unchanged on the next cycle.

  logic [W_SIZE-1:0] pc_q;
  logic              valid_q;
  logic              fault_q;
  logic [31:0]       count_q;

  logic [W_SIZE-1:0] redirect_target;
  logic [W_SIZE-1:0] next_pc;
  logic [W_SIZE-1:0] sel_dout;
  logic              region_ok;
  logic              hold_valid;
  region_sel_e       region_sel;
  logic [1:0]        unused_redirect_lsb;

  assign redirect_target     = {redirect_pc[W_SIZE-1:2], 2'b00};
  assign unused_redirect_lsb = redirect_pc[1:0];

  // A redirect beats both the post-reset replay and a stall.
  always_comb begin
    next_pc = pc_q + W_SIZE'(4);
    if (redirect_valid) begin
      next_pc = redirect_target;
    end else if (!valid_q || stall) begin
      next_pc = pc_q;
    end
  end

  assign mem.fetch_addr = rst ? next_pc : RESET_PC;

  always_comb begin
    region_sel = region_decode(pc_q[W_SIZE-1 -: 4]);
    sel_dout   = NOP;
    region_ok  = 1'b0;
    case (region_sel)
      REGION_SEL_BIOS: begin
        sel_dout  = mem.bios_dout;
        region_ok = 1'b1;
      end
      REGION_SEL_IMEM: begin
        sel_dout  = mem.imem_dout;
        region_ok = 1'b1;
      end
      default: begin
        sel_dout  = NOP;
        region_ok = 1'b0;
      end
    endcase
  end

  // The wrong-path word sitting in F/D is squashed in the redirect cycle itself.
  assign valid_fd   = valid_q && !redirect_valid && region_ok;
  assign inst_fd    = valid_fd ? sel_dout : NOP;
  assign pc_fd      = pc_q;
  assign hold_valid = stall && !redirect_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      count_q <= 32'd0;
    end else begin
      pc_q <= next_pc;
      if (!hold_valid) begin
        valid_q <= 1'b1;
      end
      if (!region_ok) begin
        fault_q <= 1'b1;
      end
      if (valid_fd && !stall) begin
        count_q <= count_q + 32'd1;
      end
    end
  end

  assign fetch_fault = fault_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table for the documented corner cases,
// then randomized stimulus checked against a PC-stream reference model.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam int W = 32;
  localparam logic [W-1:0] RST_PC = 32'h4000_0000;
  localparam logic [W-1:0] NOPW   = 32'h0000_0013;

  logic         clk = 1'b0;
  logic         rst;
  logic         stall;
  logic         redirect_valid;
  logic [W-1:0] redirect_pc;
  logic [W-1:0] pc_fd;
  logic [W-1:0] inst_fd;
  logic         valid_fd;
  logic         fetch_fault;
  logic [31:0]  fetch_count;

  fetch_stage_if #(.W_SIZE(W)) mem_if ();

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem            (mem_if),
    .pc_fd          (pc_fd),
    .inst_fd        (inst_fd),
    .valid_fd       (valid_fd),
    .fetch_fault    (fetch_fault),
    .fetch_count    (fetch_count)
  );

  // ---------------- clock / reset
  always #5 clk = ~clk;

  // ---------------- memory contents (pure functions of the address)
  function automatic logic [W-1:0] bios_word(input logic [W-1:0] a);
    return a ^ 32'h4000_0093;
  endfunction

  function automatic logic [W-1:0] imem_word(input logic [W-1:0] a);
    return {a[15:0], a[31:16]} ^ 32'h0000_0BEF;
  endfunction

  always @(posedge clk) begin
    mem_if.bios_dout <= bios_word(mem_if.fetch_addr);
    mem_if.imem_dout <= imem_word(mem_if.fetch_addr);
  end

  // ---------------- scoreboard counters
  int n_vec  = 0;
  int n_miss = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input int idx, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @%0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  // ---------------- driver
  task automatic drive(input logic r, input logic s, input logic rv, input logic [W-1:0] rpc);
    @(negedge clk);
    rst            = r;
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
  endtask

  // ---------------- directed vector table
  typedef struct {
    logic         rst_n;
    logic         stall;
    logic         rv;
    logic [W-1:0] rpc;
    logic         e_valid;
    logic [W-1:0] e_pc;
    logic [W-1:0] e_inst;
    logic [W-1:0] e_addr;
    logic         e_fault;
    logic [31:0]  e_count;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic r, input logic s, input logic rv, input logic [W-1:0] rpc,
                     input logic ev, input logic [W-1:0] epc, input logic [W-1:0] einst,
                     input logic [W-1:0] eaddr, input logic ef, input logic [31:0] ecnt);
    vec_t v;
    v.rst_n = r;  v.stall = s;  v.rv = rv;  v.rpc = rpc;
    v.e_valid = ev;  v.e_pc = epc;  v.e_inst = einst;  v.e_addr = eaddr;
    v.e_fault = ef;  v.e_count = ecnt;
    vt.push_back(v);
  endtask

  task automatic check_outputs(input int idx, input logic ev, input logic [W-1:0] epc,
                               input logic [W-1:0] einst, input logic [W-1:0] eaddr,
                               input logic ef, input logic [31:0] ecnt);
    check("valid_fd", idx, W'(valid_fd), W'(ev));
    check("pc_fd", idx, pc_fd, epc);
    check("inst_fd", idx, inst_fd, einst);
    check("fetch_addr", idx, mem_if.fetch_addr, eaddr);
    check("fetch_fault", idx, W'(fetch_fault), W'(ef));
    check("fetch_count", idx, fetch_count, ecnt);
  endtask

  // ---------------- reference model state (PC stream seen by decode)
  logic [W-1:0] m_pc;
  logic         m_bubble;
  logic         m_fault;
  logic [31:0]  m_count;

  function automatic logic mapped(input logic [W-1:0] a);
    return (a[31:28] == 4'h4) || (a[31:28] == 4'h1);
  endfunction

  function automatic logic [W-1:0] word_at(input logic [W-1:0] a);
    return (a[31:28] == 4'h4) ? bios_word(a) : imem_word(a);
  endfunction

  initial begin
    logic         r, s, rv;
    logic [W-1:0] rpc, tmp;
    logic         ev;
    logic [W-1:0] einst, eaddr;
    logic [3:0]   nib;

    rst = 1'b0;  stall = 1'b0;  redirect_valid = 1'b0;  redirect_pc = '0;

    // reset / pipeline sequence from the test plan
    add(0,0,0,32'h0,          0,32'h4000_0000,NOPW,        32'h4000_0000,0,0);
    add(1,0,0,32'h0,          0,32'h4000_0000,NOPW,        32'h4000_0000,0,0);
    add(1,0,0,32'h0,          1,32'h4000_0000,32'h93,      32'h4000_0004,0,0);
    add(1,0,0,32'h0,          1,32'h4000_0004,32'h97,      32'h4000_0008,0,1);
    // three-cycle stall at 0x4000_0008
    add(1,1,0,32'h0,          1,32'h4000_0008,32'h9B,      32'h4000_0008,0,2);
    add(1,1,0,32'h0,          1,32'h4000_0008,32'h9B,      32'h4000_0008,0,2);
    add(1,1,0,32'h0,          1,32'h4000_0008,32'h9B,      32'h4000_0008,0,2);
    add(1,0,0,32'h0,          1,32'h4000_0008,32'h9B,      32'h4000_000C,0,2);
    add(1,0,0,32'h0,          1,32'h4000_000C,32'h9F,      32'h4000_0010,0,3);
    // redirect to IMEM with misaligned low bits
    add(1,0,1,32'h1000_0022,  0,32'h4000_0010,NOPW,        32'h1000_0020,0,4);
    add(1,0,0,32'h0,          1,32'h1000_0020,32'h0020_1BEF,32'h1000_0024,0,4);
    // redirect together with stall
    add(1,1,1,32'h4000_0100,  0,32'h1000_0024,NOPW,        32'h4000_0100,0,5);
    add(1,0,0,32'h0,          1,32'h4000_0100,32'h193,     32'h4000_0104,0,5);
    // redirect into unmapped space, fault is sticky
    add(1,0,1,32'h2000_0000,  0,32'h4000_0104,NOPW,        32'h2000_0000,0,6);
    add(1,0,0,32'h0,          0,32'h2000_0000,NOPW,        32'h2000_0004,0,6);
    add(1,0,1,32'h1000_0000,  0,32'h2000_0004,NOPW,        32'h1000_0000,1,6);
    add(1,0,0,32'h0,          1,32'h1000_0000,32'h0000_1BEF,32'h1000_0004,1,6);
    // reset asserted mid-stall
    add(1,1,0,32'h0,          1,32'h1000_0004,32'h0004_1BEF,32'h1000_0004,1,7);
    add(0,1,0,32'h0,          1,32'h1000_0004,32'h0004_1BEF,32'h4000_0000,1,7);
    add(1,0,0,32'h0,          0,32'h4000_0000,NOPW,        32'h4000_0000,0,0);
    add(1,0,0,32'h0,          1,32'h4000_0000,32'h93,      32'h4000_0004,0,0);
    // redirect during the post-reset bubble
    add(0,0,0,32'h0,          1,32'h4000_0004,32'h97,      32'h4000_0000,0,1);
    add(1,0,1,32'h4000_0040,  0,32'h4000_0000,NOPW,        32'h4000_0040,0,0);
    add(1,0,0,32'h0,          1,32'h4000_0040,32'hD3,      32'h4000_0044,0,0);
    // PC wrap past the top of the address space
    add(1,0,1,32'hFFFF_FFFF,  0,32'h4000_0044,NOPW,        32'hFFFF_FFFC,0,1);
    add(1,0,0,32'h0,          0,32'hFFFF_FFFC,NOPW,        32'h0000_0000,0,1);
    add(1,0,0,32'h0,          0,32'h0000_0000,NOPW,        32'h0000_0004,1,1);

    drive(0, 0, 0, '0);
    drive(0, 0, 0, '0);
    foreach (vt[i]) begin
      drive(vt[i].rst_n, vt[i].stall, vt[i].rv, vt[i].rpc);
      check_outputs(i, vt[i].e_valid, vt[i].e_pc, vt[i].e_inst, vt[i].e_addr,
                    vt[i].e_fault, vt[i].e_count);
    end

    // randomized phase, starting from a clean reset
    drive(0, 0, 0, '0);
    m_pc = RST_PC;  m_bubble = 1'b1;  m_fault = 1'b0;  m_count = 0;
    for (int c = 0; c < 3000; c++) begin
      r   = ($urandom_range(0, 99) != 0);
      s   = ($urandom_range(0, 3) == 0);
      rv  = ($urandom_range(0, 7) == 0);
      tmp = $urandom();
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: nib = 4'h4;
        5, 6, 7, 8:    nib = 4'h1;
        default:       nib = 4'($urandom_range(0, 15));
      endcase
      rpc = {nib, tmp[27:0]};
      drive(r, s, rv, rpc);

      ev    = !m_bubble && !rv && mapped(m_pc);
      einst = ev ? word_at(m_pc) : NOPW;
      if (!r)                  eaddr = RST_PC;
      else if (rv)             eaddr = {rpc[31:2], 2'b00};
      else if (m_bubble || s)  eaddr = m_pc;
      else                     eaddr = m_pc + 32'd4;
      check_outputs(1000 + c, ev, m_pc, einst, eaddr, m_fault, m_count);

      if (r && ev && !s) exp_q.push_back(einst);
      if (valid_fd && !stall && rst) begin
        if (exp_q.size() == 0) check("accepted_stream_extra", c, inst_fd, NOPW ^ 32'hFFFF_FFFF);
        else check("accepted_stream", c, inst_fd, exp_q.pop_front());
      end

      // advance the model across the coming edge
      if (!r) begin
        m_pc = RST_PC;  m_bubble = 1'b1;  m_fault = 1'b0;  m_count = 0;
      end else begin
        if (ev && !s) m_count = m_count + 1;
        if (!mapped(m_pc)) m_fault = 1'b1;
        if (!(s && !rv)) m_bubble = 1'b0;
        m_pc = eaddr;
      end
    end
    check("exp_q_drained", 0, W'(exp_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
